// File: rtl/mult_p_pkg.sv
// Shared types and width helpers for the servo controller multiplier paths.
package mult_p_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    NORM
  } state_t;

  // Iteration counter width; kept at least one bit so a 1-bit gain still elaborates.
  function automatic int cnt_w(input int w_k);
    return (w_k > 1) ? $clog2(w_k) : 1;
  endfunction

  // One guard bit above the full product so the rounding add cannot wrap.
  function automatic int acc_w(input int w_in, input int w_k);
    return w_in + w_k + 1;
  endfunction

endpackage

// File: rtl/mult_p_seq_if.sv
// Sample/gain/result bundle between the sample front end and the proportional multiplier.
interface mult_p_seq_if #(
  parameter int W_IN  = 13,
  parameter int W_K   = 13,
  parameter int W_OUT = 26
);
  logic                    Rx_En;
  logic signed [W_IN-1:0]  Pot;
  logic signed [W_K-1:0]   Kp;
  logic                    Kp_Ld;
  logic                    Busy;
  logic                    Done;
  logic signed [W_OUT-1:0] R_Mul_P;
  logic                    Sat;
  logic                    Rx_Drop;

  modport master (
    output Rx_En, Pot, Kp, Kp_Ld,
    input  Busy, Done, R_Mul_P, Sat, Rx_Drop
  );

  modport slave (
    input  Rx_En, Pot, Kp, Kp_Ld,
    output Busy, Done, R_Mul_P, Sat, Rx_Drop
  );
endinterface

// File: rtl/mult_p_round_sat.sv
// Combinational round-half-up, arithmetic shift by FRAC, and clip to W_OUT signed bits.
module mult_p_round_sat #(
  parameter int FRAC  = 0,
  parameter int W_ACC = 27,
  parameter int W_OUT = 26
) (
  input  logic signed [W_ACC-1:0] acc,
  output logic signed [W_OUT-1:0] res,
  output logic                    sat
);

  localparam logic signed [W_ACC-1:0] HALF = W_ACC'((2 ** FRAC) / 2);

  logic signed [W_ACC-1:0] rounded;
  logic signed [W_ACC-1:0] shifted;
  logic [W_ACC-W_OUT:0]    top;

  // NOTE: every output of a combinational block gets a value up front so no latch is inferred.
  always_comb begin
    rounded = acc + HALF;
    shifted = rounded >>> FRAC;
    // The value fits only if every bit from the output sign upward agrees.
    top     = shifted[W_ACC-1:W_OUT-1];
    sat     = ~((&top) | (~|top));
    res     = shifted[W_OUT-1:0];
    if (sat) begin
      res = shifted[W_ACC-1] ? {1'b1, {(W_OUT-1){1'b0}}} : {1'b0, {(W_OUT-1){1'b1}}};
    end
  end

endmodule

// File: rtl/mult_p_seq.sv
// Sequential shift-add signed gain multiplier for the proportional path, with loadable gain.
module mult_p_seq
  import mult_p_pkg::*;
#(
  parameter int W_IN  = 13,
  parameter int W_K   = 13,
  parameter int FRAC  = 0,
  parameter int W_OUT = 26,
  parameter int K_RST = 1
) (
  input logic          Clk_G,
  input logic          Rst_G,
  mult_p_seq_if.slave  bus
);

  localparam int W_ACC = acc_w(W_IN, W_K);
  localparam int CNT_W = cnt_w(W_K);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W_K - 1);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic signed [W_ACC-1:0] acc;
  logic signed [W_ACC-1:0] pot_x;
  logic signed [W_ACC-1:0] term;
  logic [W_K-1:0]          k_work;
  logic signed [W_K-1:0]   k_reg;
  logic                    last;
  logic signed [W_OUT-1:0] rs_res, r_q;
  logic                    rs_sat, sat_q;
  logic                    busy_q, done_q, drop_q;

  assign term = pot_x <<< cnt;
  assign last = (cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.Rx_En) state_nxt = RUN;
      RUN:     if (last) state_nxt = NORM;
      NORM:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  mult_p_round_sat #(
    .FRAC  (FRAC),
    .W_ACC (W_ACC),
    .W_OUT (W_OUT)
  ) u_round_sat (
    .acc (acc),
    .res (rs_res),
    .sat (rs_sat)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk_G) begin
    if (Rst_G) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      pot_x  <= '0;
      k_work <= '0;
      k_reg  <= W_K'(K_RST);
      r_q    <= '0;
      sat_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != IDLE);
      done_q <= 1'b0;
      drop_q <= bus.Rx_En && (state != IDLE);
      if (bus.Kp_Ld) k_reg <= bus.Kp;
      unique case (state)
        IDLE: begin
          // The working copy takes the old gain even if Kp_Ld fires on this edge.
          if (bus.Rx_En) begin
            pot_x  <= W_ACC'(bus.Pot);
            k_work <= k_reg;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          // The top gain bit carries negative weight, so it subtracts.
          if (k_work[cnt]) acc <= last ? acc - term : acc + term;
          cnt <= last ? '0 : cnt + 1'b1;
        end
        NORM: begin
          r_q    <= rs_res;
          sat_q  <= rs_sat;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign bus.R_Mul_P = r_q;
  assign bus.Sat     = sat_q;
  assign bus.Rx_Drop = drop_q;

endmodule

// File: tb/tb_mult_p_seq.sv
// Self-checking bench for mult_p_seq: default build and a FRAC=8, W_OUT=16 build side by side.
module tb_mult_p_seq;

  logic Clk_G;
  logic Rst_G;
  int   errors = 0;
  int   checks = 0;

  mult_p_seq_if #(.W_IN(13), .W_K(13), .W_OUT(26)) bus_a ();
  mult_p_seq_if #(.W_IN(13), .W_K(13), .W_OUT(16)) bus_b ();

  mult_p_seq #(.W_IN(13), .W_K(13), .FRAC(0), .W_OUT(26), .K_RST(1)) dut_a (
    .Clk_G (Clk_G),
    .Rst_G (Rst_G),
    .bus   (bus_a)
  );

  mult_p_seq #(.W_IN(13), .W_K(13), .FRAC(8), .W_OUT(16), .K_RST(1)) dut_b (
    .Clk_G (Clk_G),
    .Rst_G (Rst_G),
    .bus   (bus_b)
  );

  initial Clk_G = 1'b0;
  always #5 Clk_G = ~Clk_G;

  // Reference: exact product, round half up, floor shift, clip.
  function automatic longint model(input longint pot, input longint k, input int frac,
                                   input int w_out, output bit sat);
    longint p, hi, lo;
    p  = pot * k;
    hi = (64'sd1 <<< (w_out - 1)) - 1;
    lo = -hi - 1;
    if (frac > 0) p = p + (64'sd1 <<< (frac - 1));
    p   = p >>> frac;
    sat = 1'b0;
    if (p > hi) begin p = hi; sat = 1'b1; end
    else if (p < lo) begin p = lo; sat = 1'b1; end
    return p;
  endfunction

  task automatic tick();
    @(posedge Clk_G);
    #1;
  endtask

  task automatic load_a(input int k);
    bus_a.Kp = 13'(k); bus_a.Kp_Ld = 1'b1; tick(); bus_a.Kp_Ld = 1'b0;
  endtask

  task automatic load_b(input int k);
    bus_b.Kp = 13'(k); bus_b.Kp_Ld = 1'b1; tick(); bus_b.Kp_Ld = 1'b0;
  endtask

  task automatic start_a(input int pot);
    bus_a.Pot = 13'(pot); bus_a.Rx_En = 1'b1; tick(); bus_a.Rx_En = 1'b0;
  endtask

  // Waits for Done (edges counted from the accept edge) and checks latency, result, Sat, Busy.
  task automatic finish_a(input int already, input longint exp_r, input bit exp_s, input string name);
    int n = already;
    while (!bus_a.Done && n < 40) begin tick(); n++; end
    checks++;
    if (n !== 14) begin errors++; $display("FAIL %s latency: got %0d edges expected 14", name, n); end
    checks++;
    if (longint'(bus_a.R_Mul_P) !== exp_r) begin
      errors++; $display("FAIL %s result: got %0d expected %0d", name, bus_a.R_Mul_P, exp_r);
    end
    checks++;
    if (bus_a.Sat !== exp_s || bus_a.Busy !== 1'b0) begin
      errors++; $display("FAIL %s sat/busy: got %b/%b expected %b/0", name, bus_a.Sat, bus_a.Busy, exp_s);
    end
  endtask

  task automatic run_a(input int pot, input longint exp_r, input bit exp_s, input string name);
    start_a(pot);
    checks++;
    if (bus_a.Busy !== 1'b1) begin errors++; $display("FAIL %s busy after accept: got %b expected 1", name, bus_a.Busy); end
    finish_a(0, exp_r, exp_s, name);
  endtask

  task automatic run_b(input int pot, input longint exp_r, input bit exp_s, input string name);
    int n = 0;
    bus_b.Pot = 13'(pot); bus_b.Rx_En = 1'b1; tick(); bus_b.Rx_En = 1'b0;
    while (!bus_b.Done && n < 40) begin tick(); n++; end
    checks++;
    if (n !== 14) begin errors++; $display("FAIL %s latency: got %0d edges expected 14", name, n); end
    checks++;
    if (longint'(bus_b.R_Mul_P) !== exp_r || bus_b.Sat !== exp_s) begin
      errors++;
      $display("FAIL %s result/sat: got %0d/%b expected %0d/%b", name, bus_b.R_Mul_P, bus_b.Sat, exp_r, exp_s);
    end
  endtask

  task automatic test_reset();
    Rst_G = 1'b1; tick(); tick();
    checks++;
    if ({bus_a.R_Mul_P, bus_a.Sat, bus_a.Done, bus_a.Busy, bus_a.Rx_Drop} !== '0 ||
        {bus_b.R_Mul_P, bus_b.Sat, bus_b.Done, bus_b.Busy, bus_b.Rx_Drop} !== '0) begin
      errors++; $display("FAIL reset outputs: got a=%0d b=%0d expected all zero", bus_a.R_Mul_P, bus_b.R_Mul_P);
    end
    Rst_G = 1'b0; tick();
  endtask

  task automatic test_basic();
    load_a(3);
    run_a(100, 300, 1'b0, "basic_pos");
    run_a(-100, -300, 1'b0, "basic_neg");
  endtask

  task automatic test_sign_bit();
    load_a(-4096);
    run_a(-4096, 16777216, 1'b0, "sign_min_min");
    load_a(4095);
    run_a(-4096, -16773120, 1'b0, "sign_max_min");
  endtask

  task automatic test_frac();
    load_b(384);  run_b(1000, 1500, 1'b0, "frac_scale");
    load_b(128);  run_b(-3, -1, 1'b0, "frac_half_up");
    load_b(4095); run_b(4095, 32767, 1'b1, "frac_sat_hi");
    run_b(-4096, -32768, 1'b1, "frac_sat_lo");
  endtask

  task automatic test_drop_back_to_back();
    int drops = 0;
    int dones = 0;
    load_a(5);
    start_a(37);
    for (int e = 1; e <= 13; e++) begin
      bus_a.Rx_En = (e == 3 || e == 13);
      bus_a.Pot   = 13'($urandom_range(8191));
      tick();
      if (bus_a.Rx_En) begin
        checks++;
        if (bus_a.Rx_Drop !== 1'b1) begin errors++; $display("FAIL drop pulse e=%0d: got %b expected 1", e, bus_a.Rx_Drop); end
      end
      drops += int'(bus_a.Rx_Drop);
      dones += int'(bus_a.Done);
    end
    bus_a.Rx_En = 1'b0;
    checks++;
    if (drops !== 2 || dones !== 0) begin
      errors++; $display("FAIL drop count: got drops=%0d dones=%0d expected 2/0", drops, dones);
    end
    finish_a(13, 185, 1'b0, "drop_first_result");
    // Rx_En raised during the Done cycle is accepted on the next edge.
    start_a(-21);
    checks++;
    if (bus_a.Busy !== 1'b1 || bus_a.Rx_Drop !== 1'b0) begin
      errors++; $display("FAIL b2b accept: got busy=%b drop=%b expected 1/0", bus_a.Busy, bus_a.Rx_Drop);
    end
    finish_a(0, -105, 1'b0, "b2b_result");
  endtask

  task automatic test_kp_load();
    load_a(3);
    start_a(10);
    tick(); tick(); tick();
    bus_a.Kp = 13'(7); bus_a.Kp_Ld = 1'b1; tick(); bus_a.Kp_Ld = 1'b0;
    finish_a(4, 30, 1'b0, "kp_mid_run_old");
    run_a(10, 70, 1'b0, "kp_mid_run_new");
    // Load and accept on the same edge: old gain used, new gain kept.
    bus_a.Kp = 13'(2); bus_a.Kp_Ld = 1'b1;
    start_a(10);
    bus_a.Kp_Ld = 1'b0;
    finish_a(0, 70, 1'b0, "kp_same_edge_old");
    run_a(10, 20, 1'b0, "kp_same_edge_new");
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    load_a(6);
    start_a(9);
    for (int i = 0; i < 5; i++) tick();
    Rst_G = 1'b1; tick(); Rst_G = 1'b0;
    checks++;
    if ({bus_a.R_Mul_P, bus_a.Sat, bus_a.Done, bus_a.Busy, bus_a.Rx_Drop} !== '0) begin
      errors++; $display("FAIL reset_mid outputs: got r=%0d busy=%b done=%b expected zero", bus_a.R_Mul_P, bus_a.Busy, bus_a.Done);
    end
    for (int i = 0; i < 16; i++) begin tick(); dones += int'(bus_a.Done); end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL reset_mid aborted done: got %0d expected 0", dones); end
    run_a(9, 9, 1'b0, "reset_mid_krst");
  endtask

  task automatic test_random();
    longint exp_r;
    bit     exp_s;
    int     pot, k;
    for (int i = 0; i < 20; i++) begin
      pot = int'($urandom_range(8191)) - 4096;
      k   = int'($urandom_range(8191)) - 4096;
      exp_r = model(pot, k, 0, 26, exp_s);
      load_a(k);
      run_a(pot, exp_r, exp_s, "rand_a");
    end
    for (int i = 0; i < 20; i++) begin
      pot = (i < 10) ? int'($urandom_range(8191)) - 4096 : int'($urandom_range(511)) - 256;
      k   = int'($urandom_range(8191)) - 4096;
      exp_r = model(pot, k, 8, 16, exp_s);
      load_b(k);
      run_b(pot, exp_r, exp_s, "rand_b");
    end
  endtask

  initial begin
    Rst_G = 1'b1;
    bus_a.Rx_En = 1'b0; bus_a.Pot = '0; bus_a.Kp = '0; bus_a.Kp_Ld = 1'b0;
    bus_b.Rx_En = 1'b0; bus_b.Pot = '0; bus_b.Kp = '0; bus_b.Kp_Ld = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_sign_bit();
    test_frac();
    test_drop_back_to_back();
    test_kp_load();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
